// File: rtl/mem_latency_responder_pkg.sv
// Shared constants and types for the cache-fill memory port.
// The cache-fill controller and the cache data array import the same
// package, so word width, address width and default latency live here only.
package mem_latency_responder_pkg;

  // Data word carried on the memory port.
  localparam int MEM_WORD_W = 16;

  // Byte address width on the memory port (64KB byte space).
  localparam int MEM_ADDR_W = 16;

  // Default read latency, request edge to data_valid. Legal range is 1..8.
  localparam int MEM_LATENCY = 4;

  // Request kind, decoded from the wr bit of an accepted request.
  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_t;

  // One slot of the read-response pipeline.
  typedef struct packed {
    logic                  valid;
    logic [MEM_WORD_W-1:0] data;
  } resp_slot_t;

  // The bus shows a word only while its strobe is high, and zero otherwise,
  // so a stale word never reaches the requester.
  function automatic logic [MEM_WORD_W-1:0] gate_word(
    input logic                  valid,
    input logic [MEM_WORD_W-1:0] word
  );
    return valid ? word : '0;
  endfunction

endpackage

// File: rtl/mem_latency_responder_if.sv
// Memory port between a cache-fill requester (master) and the backing
// store responder (slave).
//
// Handshake: the master presents one request per cycle by holding enable=1
// together with wr/addr/data_in across a rising clock edge; the request is
// accepted at that edge unconditionally (there is no ready). A read returns
// exactly one response: data_valid=1 with data_out for a single cycle, a
// fixed number of cycles later. There is no backpressure, so the master must
// take data_out in every cycle data_valid is high. data_out is zero whenever
// data_valid is low.
interface mem_latency_responder_if;
  import mem_latency_responder_pkg::*;

  logic                  enable;
  logic                  wr;
  logic [MEM_ADDR_W-1:0] addr;
  logic [MEM_WORD_W-1:0] data_in;
  logic [MEM_WORD_W-1:0] data_out;
  logic                  data_valid;

  // Requester side (cache-fill controller or testbench).
  modport master (
    output enable,
    output wr,
    output addr,
    output data_in,
    input  data_out,
    input  data_valid
  );

  // Responder side (backing store).
  modport slave (
    input  enable,
    input  wr,
    input  addr,
    input  data_in,
    output data_out,
    output data_valid
  );

endinterface

// File: rtl/mem_latency_responder_resp_pipe.sv
// Read-response pipeline: a LATENCY-stage shift register of {valid, data}.
// Stage 0 is loaded from the issue logic on the request edge; the last stage
// drives data_valid and the gated data_out. Only the valid bits are reset,
// which is enough to discard in-flight reads: a word with a cleared valid bit
// is never shown on the bus.
module mem_latency_responder_resp_pipe
  import mem_latency_responder_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  resp_slot_t            in_slot,
  output logic                  out_valid,
  output logic [MEM_WORD_W-1:0] out_data
);

  logic [LATENCY-1:0]    valid_q;
  logic [MEM_WORD_W-1:0] data_q [LATENCY];

  // Valid bits shift one stage per cycle; reset empties the whole pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_slot.valid;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Data words travel alongside their valid bits; left unreset on purpose.
  always_ff @(posedge clk) begin
    data_q[0] <= in_slot.data;
    for (int i = 1; i < LATENCY; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = gate_word(valid_q[LATENCY-1], data_q[LATENCY-1]);

endmodule

// File: rtl/mem_latency_responder.sv
// Memory-side responder for the cache-fill protocol: a word-wide backing
// store with a fixed read latency. Writes commit on the request edge and
// produce no response. Reads sample the store on the request edge and the
// sampled word is returned LATENCY cycles later through the response pipe.
// Because the word is sampled at issue, a read already in flight returns the
// old data even if a later write to the same word commits before it emerges.
module mem_latency_responder
  import mem_latency_responder_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY,  // 1..8
  parameter int ADDR_W  = 15            // word-index width
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_latency_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [MEM_WORD_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     word_idx;
  req_kind_t             kind;
  logic                  wr_fire;
  logic                  rd_fire;
  resp_slot_t            issue_slot;

  // The byte-select bit is ignored: an odd byte address reads its word.
  assign word_idx = bus.addr[ADDR_W:1];
  assign kind     = req_kind_t'(bus.wr);

  // Requests presented while reset is asserted are dropped entirely.
  assign wr_fire = rst_n && bus.enable && (kind == REQ_WRITE);
  assign rd_fire = rst_n && bus.enable && (kind == REQ_READ);

  // The byte-select bit and any address bits above the word index are
  // don't-care; upper bits simply alias onto the same store.
  logic unused_byte_sel;
  assign unused_byte_sel = bus.addr[0];

  if (ADDR_W < MEM_ADDR_W - 1) begin : g_alias
    logic unused_alias_bits;
    assign unused_alias_bits = ^bus.addr[MEM_ADDR_W-1:ADDR_W+1];
  end

  // Write commit: the store is updated on the request edge. Contents survive
  // reset; only the response pipeline is cleared.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[word_idx] <= bus.data_in;
    end
  end

  // Read sample: the current word is captured into stage 0 on the request
  // edge. A single port means a read and a write never share an edge.
  always_comb begin
    issue_slot       = '0;
    issue_slot.valid = rd_fire;
    issue_slot.data  = mem_q[word_idx];
  end

  mem_latency_responder_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_mem_resp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_slot   (issue_slot),
    .out_valid (bus.data_valid),
    .out_data  (bus.data_out)
  );

endmodule

// File: tb/tb_mem_latency_responder.sv
// Directed bench for mem_latency_responder (LATENCY=4, ADDR_W=15).
// Inputs are driven 1ns after each rising edge and outputs are sampled at
// the same point, so a check placed right after tick() sees the state
// produced by the edge that tick() waited for.
module tb_mem_latency_responder;
  import mem_latency_responder_pkg::*;

  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_latency_responder_if bus_if ();

  mem_latency_responder #(
    .LATENCY (LAT),
    .ADDR_W  (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    bus_if.enable  = en;
    bus_if.wr      = w;
    bus_if.addr    = a;
    bus_if.data_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, a, d);
    tick();
    idle();
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic check(input string tag, input logic exp_v, input logic [15:0] exp_d);
    checks++;
    assert ({bus_if.data_valid, bus_if.data_out} === {exp_v, exp_d}) else begin
      failures++;
      $error("FAIL %s: observed valid=%0b data=%h, expected valid=%0b data=%h",
             tag, bus_if.data_valid, bus_if.data_out, exp_v, exp_d);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One isolated read: quiet for LAT-1 cycles, one response, quiet again.
  task automatic read_probe(input string tag, input logic [15:0] a, input logic [15:0] exp_d);
    drive(1'b1, 1'b0, a, 16'h0000);
    for (int k = 0; k <= LAT; k++) begin
      tick();
      if (k == 0) idle();
      if (k == LAT - 1) check(tag, 1'b1, exp_d);
      else              check(tag, 1'b0, 16'h0000);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] fill_base;
    logic [15:0] fill_exp;
    int          wait_cnt;

    rst_n = 1'b0;
    idle();

    // T1: reset held with a read request present; nothing may come out.
    drive(1'b1, 1'b0, 16'h0240, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_in_reset", 1'b0, 16'h0000);
    end
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t1_after_reset", 1'b0, 16'h0000);
    end

    // T2: word 0x0120 = BEEF, read via even and odd byte address.
    write_word(16'h0240, 16'hBEEF);
    write_word(16'h0242, 16'h1234);
    read_probe("t2_even", 16'h0240, 16'hBEEF);
    read_probe("t2_odd", 16'h0241, 16'hBEEF);
    read_probe("t2_next_word", 16'h0243, 16'h1234);

    // T3: eight back-to-back reads return A000..A007 with no gaps.
    for (int i = 0; i < 8; i++) begin
      write_word(16'h1000 + 16'(2 * i), 16'hA000 + 16'(i));
    end
    for (int c = 0; c < 8 + LAT; c++) begin
      if (c < 8) begin
        drive(1'b1, 1'b0, 16'h1000 + 16'(2 * c), 16'h0000);
        exp_q.push_back(16'hA000 + 16'(c));
      end else begin
        idle();
      end
      tick();
      if (c >= LAT - 1 && exp_q.size() > 0) check("t3_burst", 1'b1, exp_q.pop_front());
      else                                  check("t3_burst_quiet", 1'b0, 16'h0000);
    end

    // T4: read old, overwrite, read new; the bubble stays empty.
    write_word(16'h2000, 16'h1111);
    drive(1'b1, 1'b0, 16'h2000, 16'h0000);
    tick();
    check("t4_c1", 1'b0, 16'h0000);
    drive(1'b1, 1'b1, 16'h2000, 16'h2222);
    tick();
    check("t4_c2", 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 16'h2000, 16'h0000);
    tick();
    idle();
    check("t4_c3", 1'b0, 16'h0000);
    tick();
    check("t4_old_data", 1'b1, 16'h1111);
    tick();
    check("t4_bubble", 1'b0, 16'h0000);
    tick();
    check("t4_new_data", 1'b1, 16'h2222);
    tick();
    check("t4_after", 1'b0, 16'h0000);

    // T5: reset while three reads are in flight, with a write presented
    // during reset that must be ignored.
    write_word(16'h4000, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'h4000, 16'h0000);
      tick();
      check("t5_issue", 1'b0, 16'h0000);
    end
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 16'h4000, 16'hDEAD);
    tick();
    check("t5_reset_edge", 1'b0, 16'h0000);
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_flushed", 1'b0, 16'h0000);
    end
    read_probe("t5_write_ignored", 16'h4000, 16'h5555);

    // T6: cache-fill requester, miss on 0x3456 fills 0x3450..0x345E.
    // One request per response, with varying idle gaps before each one.
    fill_base = 16'h3456 & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      write_word(fill_base + 16'(2 * i), 16'hC000 + 16'(17 * i));
    end
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < i % 3; g++) begin
        tick();
        check("t6_gap", 1'b0, 16'h0000);
      end
      fill_exp = 16'hC000 + 16'(17 * i);
      drive(1'b1, 1'b0, fill_base + 16'(2 * i), 16'h0000);
      tick();
      idle();
      wait_cnt = 0;
      while (bus_if.data_valid !== 1'b1 && wait_cnt < 16) begin
        tick();
        wait_cnt++;
      end
      check_int("t6_latency", wait_cnt, LAT - 1);
      check("t6_word", 1'b1, fill_exp);
    end
    tick();
    check("t6_done", 1'b0, 16'h0000);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
